// File: rtl/seg_scan_driver_if.sv
// Load/display bundle for seg_scan_driver: the master drives the load side, the slave (driver) drives the display side.
interface seg_scan_driver_if #(
    parameter int SEG_COUNT = 4
);
    logic                   load;
    logic [4*SEG_COUNT-1:0] digits;
    logic [SEG_COUNT-1:0]   dp;
    logic [SEG_COUNT-1:0]   blank;
    logic [7:0]             seg;
    logic [SEG_COUNT-1:0]   an;
    logic                   frame_done;
    logic                   pending;

    modport master (
        output load, digits, dp, blank,
        input  seg, an, frame_done, pending
    );

    modport slave (
        input  load, digits, dp, blank,
        output seg, an, frame_done, pending
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with frame-aligned double buffering.
// Optional macro SEG_LZB_EN enables leading-zero blanking.
module seg_scan_driver #(
    parameter int SEG_COUNT = 4,
    parameter int CLK_DIV   = 50000
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(SEG_COUNT);

    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [4*SEG_COUNT-1:0] r_pend_dig, r_act_dig;
    logic [SEG_COUNT-1:0]   r_pend_dp, r_act_dp;
    logic [SEG_COUNT-1:0]   r_pend_bl, r_act_bl;
    logic                   r_pending;
    logic                   r_frame_done;
    logic [7:0]             r_seg;
    logic [SEG_COUNT-1:0]   r_an;

    logic                   w_last_cnt, w_bnd;
    logic [CW-1:0]          w_cnt_nxt;
    logic [IW-1:0]          w_idx_nxt;
    logic [4*SEG_COUNT-1:0] w_act_dig_nxt;
    logic [SEG_COUNT-1:0]   w_act_dp_nxt, w_act_bl_nxt;
    logic [3:0]             w_nib;
    logic                   w_dp_bit, w_bl_bit, w_dark;
    logic [7:0]             w_seg_nxt;
    logic [SEG_COUNT-1:0]   w_an_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign w_last_cnt = (r_cnt == CW'(CLK_DIV - 1));
    assign w_bnd      = w_last_cnt && (r_idx == IW'(SEG_COUNT - 1));
    assign w_cnt_nxt  = w_last_cnt ? '0 : r_cnt + CW'(1);

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_last_cnt)
            w_idx_nxt = (r_idx == IW'(SEG_COUNT - 1)) ? '0 : r_idx + IW'(1);
    end

    // A load on the boundary cycle bypasses the pending buffer entirely.
    always_comb begin
        w_act_dig_nxt = r_act_dig;
        w_act_dp_nxt  = r_act_dp;
        w_act_bl_nxt  = r_act_bl;
        if (w_bnd && bus.load) begin
            w_act_dig_nxt = bus.digits;
            w_act_dp_nxt  = bus.dp;
            w_act_bl_nxt  = bus.blank;
        end else if (w_bnd && r_pending) begin
            w_act_dig_nxt = r_pend_dig;
            w_act_dp_nxt  = r_pend_dp;
            w_act_bl_nxt  = r_pend_bl;
        end
    end

    always_comb begin
        w_nib    = 4'h0;
        w_dp_bit = 1'b0;
        w_bl_bit = 1'b0;
        for (int i = 0; i < SEG_COUNT; i++) begin
            if (w_idx_nxt == IW'(i)) begin
                w_nib    = w_act_dig_nxt[4*i +: 4];
                w_dp_bit = w_act_dp_nxt[i];
                w_bl_bit = w_act_bl_nxt[i];
            end
        end
    end

`ifdef SEG_LZB_EN
    logic [SEG_COUNT-1:0] w_lzb;

    // Digits above the most significant nonzero-or-dp digit are dark; digit 0 never is.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        w_lzb = '0;
        for (int i = SEG_COUNT - 1; i >= 1; i--) begin
            if ((w_act_dig_nxt[4*i +: 4] != 4'h0) || w_act_dp_nxt[i])
                seen = 1'b1;
            w_lzb[i] = ~seen;
        end
    end

    always_comb begin
        w_dark = w_bl_bit;
        for (int i = 0; i < SEG_COUNT; i++)
            if ((w_idx_nxt == IW'(i)) && w_lzb[i])
                w_dark = 1'b1;
    end
`else
    assign w_dark = w_bl_bit;
`endif

    always_comb begin
        w_seg_nxt = 8'hFF;
        w_an_nxt  = '1;
        if (w_cnt_nxt != '0) begin
            w_an_nxt = ~(SEG_COUNT'(1) << w_idx_nxt);
            if (!w_dark)
                w_seg_nxt = ~{w_dp_bit, hex7(w_nib)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend_dig   <= '0;
            r_pend_dp    <= '0;
            r_pend_bl    <= '0;
            r_act_dig    <= '0;
            r_act_dp     <= '0;
            r_act_bl     <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_seg        <= 8'hFF;
            r_an         <= '1;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_act_dig    <= w_act_dig_nxt;
            r_act_dp     <= w_act_dp_nxt;
            r_act_bl     <= w_act_bl_nxt;
            r_frame_done <= w_bnd;
            r_seg        <= w_seg_nxt;
            r_an         <= w_an_nxt;
            if (bus.load && !w_bnd) begin
                r_pend_dig <= bus.digits;
                r_pend_dp  <= bus.dp;
                r_pend_bl  <= bus.blank;
                r_pending  <= 1'b1;
            end else if (w_bnd) begin
                r_pending  <= 1'b0;
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;
    assign bus.pending    = r_pending;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (SEG_COUNT=4, CLK_DIV=4): directed steps plus random loads against a timeline model.
module tb_seg_scan_driver;
    localparam int SC = 4;
    localparam int CD = 4;
    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic rst = 1'b0;
    seg_scan_driver_if #(.SEG_COUNT(SC)) ifc ();

    seg_scan_driver #(.SEG_COUNT(SC), .CLK_DIV(CD)) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: t = edges since reset release; active/pending contents tracked as plain values.
    int          t;
    logic [15:0] a_dig, p_dig, c_dig;
    logic [3:0]  a_dp, p_dp, a_bl, p_bl, c_dp, c_bl;
    bit          m_pend, m_fd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_seg();
        int c, i, lead;
        c = t % CD;
        i = (t / CD) % SC;
        lead = 0;
        if (c == 0) return 8'hFF;
        if (a_bl[i]) return 8'hFF;
`ifdef SEG_LZB_EN
        for (int j = 0; j < SC; j++)
            if (a_dig[4*j +: 4] != 4'h0 || a_dp[j]) lead = j;
        if (i > lead) return 8'hFF;
`endif
        return ~{a_dp[i], HEX[a_dig[4*i +: 4]]};
    endfunction

    function automatic logic [3:0] exp_an();
        if (t % CD == 0) return 4'hF;
        return ~(4'b0001 << ((t / CD) % SC));
    endfunction

    task automatic model_reset();
        t = 0; a_dig = '0; a_dp = '0; a_bl = '0;
        p_dig = '0; p_dp = '0; p_bl = '0; m_pend = 0; m_fd = 0;
    endtask

    task automatic cyc(input bit ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        bit bnd;
        @(negedge clk);
        ifc.load = ld; ifc.digits = d; ifc.dp = p; ifc.blank = b;
        @(posedge clk);
        bnd = (t % (CD * SC)) == (CD * SC - 1);
        if (ld && bnd) begin
            a_dig = d; a_dp = p; a_bl = b; m_pend = 0;
        end else begin
            if (bnd && m_pend) begin a_dig = p_dig; a_dp = p_dp; a_bl = p_bl; m_pend = 0; end
            if (ld) begin p_dig = d; p_dp = p; p_bl = b; m_pend = 1; end
        end
        m_fd = bnd;
        t++;
        #1;
        chk("seg", 32'(ifc.seg), 32'(exp_seg()));
        chk("an", 32'(ifc.an), 32'(exp_an()));
        chk("frame_done", 32'(ifc.frame_done), 32'(m_fd));
        chk("pending", 32'(ifc.pending), 32'(m_pend));
    endtask

    task automatic idle();
        cyc(0, c_dig, c_dp, c_bl);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        c_dig = d; c_dp = p; c_bl = b;
        cyc(1, d, p, b);
    endtask

    // Advance to the first lit cycle of slot k.
    task automatic run_to(input int k);
        bit ok;
        ok = 0;
        for (int n = 0; n < 64; n++) begin
            if (t % CD == 1 && (t / CD) % SC == k) begin ok = 1; break; end
            idle();
        end
        chk("run_to_timeout", 32'(ok), 32'd1);
    endtask

    // Advance to digit 0 of the first frame showing everything loaded so far.
    task automatic wait_frame();
        bit ok;
        ok = 0;
        for (int n = 0; n < 64; n++) begin
            idle();
            if (!m_pend && t % (CD * SC) == 1) begin ok = 1; break; end
        end
        chk("wait_frame_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int pulses;
        model_reset();
        c_dig = '0; c_dp = '0; c_bl = '0;
        ifc.load = 0; ifc.digits = '0; ifc.dp = '0; ifc.blank = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        for (int n = 0; n < 6; n++) idle();

        // 1: reset mid-slot takes effect before any edge
        @(negedge clk); #2 rst = 0; #1;
        chk("rst_seg", 32'(ifc.seg), 32'hFF);
        chk("rst_an", 32'(ifc.an), 32'hF);
        chk("rst_fd", 32'(ifc.frame_done), 32'd0);
        chk("rst_pending", 32'(ifc.pending), 32'd0);
        @(posedge clk); #1 rst = 1;
        model_reset();
        idle();
        chk("first_slot_an", 32'(ifc.an), 32'hE);
        chk("first_slot_seg", 32'(ifc.seg), 32'hC0);

        // 2: 12AF
        load(16'h12AF, 4'h0, 4'h0);
        wait_frame();
        chk("d0_12AF", 32'(ifc.seg), 32'h8E);
        run_to(1); chk("d1_12AF", 32'(ifc.seg), 32'h88);
        run_to(2); chk("d2_12AF", 32'(ifc.seg), 32'hA4);
        run_to(3); chk("d3_12AF", 32'(ifc.seg), 32'hF9); chk("d3_an", 32'(ifc.an), 32'h7);

        // 3: mid-frame load waits for the boundary
        run_to(1);
        load(16'h3333, 4'h0, 4'h0);
        chk("mid_pending", 32'(ifc.pending), 32'd1);
        run_to(3); chk("old_d3", 32'(ifc.seg), 32'hF9);
        pulses = 0;
        for (int n = 0; n < 64 && !(t % (CD * SC) == 1); n++) begin
            idle();
            if (ifc.frame_done) pulses++;
        end
        chk("fd_pulses", 32'(pulses), 32'd1);
        chk("commit_pending", 32'(ifc.pending), 32'd0);
        chk("d0_3333", 32'(ifc.seg), 32'hB0);

        // 4: load exactly on the boundary cycle
        for (int n = 0; n < 64 && (t % (CD * SC)) != (CD * SC - 1); n++) idle();
        load(16'h4567, 4'h0, 4'h0);
        chk("bypass_pending", 32'(ifc.pending), 32'd0);
        chk("bypass_fd", 32'(ifc.frame_done), 32'd1);
        run_to(0); chk("bypass_d0", 32'(ifc.seg), 32'hF8);

        // 5: blank and dp
        load(16'h8888, 4'b0001, 4'b0100);
        wait_frame();
        chk("d0_8888", 32'(ifc.seg), 32'h00);
        run_to(1); chk("d1_8888", 32'(ifc.seg), 32'h80);
        run_to(2); chk("d2_blank", 32'(ifc.seg), 32'hFF); chk("d2_blank_an", 32'(ifc.an), 32'hB);
        run_to(3); chk("d3_8888", 32'(ifc.seg), 32'h80);

        // 6: leading zeros
        load(16'h0050, 4'h0, 4'h0);
        wait_frame();
        chk("d0_0050", 32'(ifc.seg), 32'hC0);
        run_to(1); chk("d1_0050", 32'(ifc.seg), 32'h92);
`ifdef SEG_LZB_EN
        run_to(2); chk("d2_lzb", 32'(ifc.seg), 32'hFF);
        run_to(3); chk("d3_lzb", 32'(ifc.seg), 32'hFF);
`else
        run_to(2); chk("d2_zero", 32'(ifc.seg), 32'hC0);
        run_to(3); chk("d3_zero", 32'(ifc.seg), 32'hC0);
`endif

        // Random loads, including bursts and boundary coincidences
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                logic [15:0] rd;
                logic [3:0]  rp, rb;
                rd = 16'($urandom);
                if ($urandom_range(0, 2) == 0) rd[15:8] = 8'h00;
                rp = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
                rb = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
                load(rd, rp, rb);
            end else begin
                idle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
